pbus_slot: RTL and testbench
============================

Name: pbus_slot

Overview:
- Bus-slave peripheral for the two expansion slots.
- Sits downstream of the bus controller on the CPU en/wr/addr/data/wt handshake, in the same way as the timer, serial and disk devices.
- Converts each CPU access into one timed 16-bit read or write cycle on the shared peripheral bus (pbus_d/pbus_a/read_n/write_n), driving slot1_cs_n or slot2_cs_n.
- The peripheral bus is shared with the disk controller, so every cycle is preceded by a request/grant handshake with the toplevel pbus arbiter.

Parameters:
- SETUP_CYC, 2: cycles from address/cs valid to strobe assertion (min 1).
- STROBE_CYC, 6: cycles read_n/write_n held low (min 1).
- HOLD_CYC, 2: cycles address/cs/write data held after strobe release (min 1).
- TIMEOUT_CYC, 255: max extra strobe cycles while iordy is low (only with PBUS_SLOT_IORDY_EN).

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- en  input  1  access request from the bus controller
- wr  input  1  1=write, 0=read; sampled with en
- addr  input  6  [7:2] of the CPU address; addr[7] selects slot (0=slot1, 1=slot2), addr[6:2] drive pbus_a
- data_in  input  16  write data
- data_out  output  16  read data
- wt  output  1  wait; 1 stalls the CPU
- pbus_req  output  1  request for the peripheral bus
- pbus_gnt  input  1  grant from the arbiter
- pbus_a  output  5  peripheral bus address
- pbus_d_in  input  16  peripheral bus data in
- pbus_d_out  output  16  peripheral bus data out
- pbus_d_oe  output  1  output enable for the pbus_d tristate (tristate lives in the toplevel)
- pbus_read_n  output  1  read strobe
- pbus_write_n  output  1  write strobe
- slot1_cs_n  output  1  slot 1 chip select
- slot2_cs_n  output  1  slot 2 chip select
- iordy  input  1  slot ready (only used with PBUS_SLOT_IORDY_EN)

Behaviour:
- Clocking and reset: single clock domain, rising edge. Reset is asynchronous and active-high.
- Reset values:
  - state=IDLE, wt=1 when en=1 (wt = en & ~done)
  - data_out=0, pbus_req=0, pbus_a=0, pbus_d_out=0, pbus_d_oe=0
  - read_n=1, write_n=1, slot1_cs_n=1, slot2_cs_n=1
- State machine IDLE -> REQ -> SETUP -> STROBE -> HOLD -> DONE -> IDLE:
  - IDLE: on en=1, latch wr, addr, data_in; raise pbus_req. Go to SETUP if pbus_gnt=1 in the same cycle, else REQ.
  - REQ: hold pbus_req=1; go to SETUP on pbus_gnt=1.
  - SETUP: drive pbus_a=addr[6:2] and the selected cs_n=0. For writes, pbus_d_oe=1 and pbus_d_out=latched data. Lasts SETUP_CYC cycles.
  - STROBE: read_n=0 (read) or write_n=0 (write) for STROBE_CYC cycles. On a read, pbus_d_in is captured into data_out at the last strobe cycle's edge.
  - HOLD: strobes=1; address, cs and write data are held for HOLD_CYC cycles.
  - DONE: 1 cycle; deassert cs, oe and pbus_req; wt=0 for exactly this cycle. Next state IDLE.
- Latency with grant available: wt goes low in cycle 1+SETUP_CYC+STROBE_CYC+HOLD_CYC after en is first sampled. Default: cycle 11.
- Back-to-back accesses: if en is still high in IDLE after DONE, a new access starts. This gives at least one idle cycle between strobes.
- data_out holds its value until the next completed read. Writes leave data_out unchanged.
- Arbitration: grant loss after SETUP has begun is ignored (the arbiter is non-preemptive). pbus_req stays high from IDLE exit through HOLD.
- Counter: one down-counter, 8 bits, loaded with N-1 on state entry; the state advances when it reaches 0.
- Reset mid-cycle: every strobe, cs and oe returns to inactive immediately (asynchronously), and the cycle is abandoned.

Optional Feature:
- Macro: PBUS_SLOT_IORDY_EN.
- When defined:
  - On the last STROBE cycle, if iordy=0, the strobe is extended cycle by cycle until iordy=1. The read is captured on the first cycle with iordy=1.
  - After TIMEOUT_CYC extra cycles the cycle completes anyway: data_out=16'hFFFF and sticky status bit timeout_flag is set.
  - timeout_flag is readable on output port timeout (1 bit, reset 0) and is cleared by the next access that completes without timeout.
- When undefined: iordy is ignored, the timeout port is tied 0, and strobe length is exactly STROBE_CYC.

Decomposition:
- Package pbus_slot_pkg holds:
  - state enum encoding (IDLE, REQ, SETUP, STROBE, HOLD, DONE)
  - counter width constant CNT_W=8
  - pbus address width constant 5
  - slot-select bit index 7
- Sub-module pbus_cycle_timer: loadable 8-bit down-counter with load value and a zero flag. It is reused by the disk controller's PIO timing.

Test Plan:
1. Reset: assert reset while idle, with en=0 -> all strobes and cs_n=1, oe=0, req=0, data_out=0.
2. Read slot1, gnt=1: en=1, wr=0, addr=6'h05, pbus_d_in=16'hA5C3 -> slot1_cs_n=0 from cycle 1, read_n low for cycles 3-8, data_out=16'hA5C3, wt=0 in cycle 11 only.
3. Write slot2, gnt delayed 4 cycles: addr=6'h21, data_in=16'h1234 -> req high immediately, no cs until gnt; slot2_cs_n=0, pbus_a=5'h01, oe=1 with d_out=16'h1234; write_n low 6 cycles; wt low in cycle 15.
4. Reset mid-STROBE: assert reset at cycle 5 of a write -> write_n, cs_n and oe deassert in the same cycle without a clock edge; state=IDLE after release.
5. Back-to-back: hold en=1 across two reads -> exactly one DONE per access; the two read_n pulses are separated by at least HOLD_CYC+SETUP_CYC+1 high cycles.
6. With PBUS_SLOT_IORDY_EN:
   - iordy low 3 extra cycles -> strobe 9 cycles long, data captured after iordy rises.
   - iordy stuck low -> completes after 255 extra cycles with data_out=16'hFFFF and timeout=1.

Source files
------------

// File: rtl/pbus_slot_pkg.sv
// Shared types and constants for the expansion-slot bus slave.
// The strobe-extension option is enabled by defining PBUS_SLOT_IORDY_EN.
package pbus_slot_pkg;

    localparam int CNT_W        = 8;   // cycle timer width
    localparam int PA_W         = 5;   // peripheral bus address width
    localparam int SLOT_SEL_BIT = 7;   // CPU address bit that picks the slot
    localparam int ADDR_LSB     = 2;   // CPU address bit carried by addr[0]

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        SETUP,
        STROBE,
        HOLD,
        DONE
    } state_t;

    // Timer load value for a phase lasting n cycles (the phase ends on zero).
    function automatic logic [CNT_W-1:0] phase_load(input int n);
        return CNT_W'(n - 1);
    endfunction

endpackage

// File: rtl/pbus_cycle_timer.sv
// Loadable down-counter with a zero flag; times the phases of a pbus cycle.
// Also used by the disk controller's PIO timing.
module pbus_cycle_timer
    import pbus_slot_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);

    logic [CNT_W-1:0] count;

    // Load on request, otherwise count down and park at zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/pbus_slot.sv
// Expansion-slot bus slave: turns one CPU access into one timed 16-bit
// read or write cycle on the shared peripheral bus, after winning the
// pbus arbiter. Define PBUS_SLOT_IORDY_EN to let a slot stretch the strobe
// through iordy, with a timeout that reports on the timeout port.
module pbus_slot
    import pbus_slot_pkg::*;
#(
    parameter int SETUP_CYC   = 2,
    parameter int STROBE_CYC  = 6,
    parameter int HOLD_CYC    = 2,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic        wr,
    input  logic [5:0]  addr,
    input  logic [15:0] data_in,
    output logic [15:0] data_out,
    output logic        wt,
    output logic        pbus_req,
    input  logic        pbus_gnt,
    output logic [PA_W-1:0] pbus_a,
    input  logic [15:0] pbus_d_in,
    output logic [15:0] pbus_d_out,
    output logic        pbus_d_oe,
    output logic        pbus_read_n,
    output logic        pbus_write_n,
    output logic        slot1_cs_n,
    output logic        slot2_cs_n,
    input  logic        iordy,
    output logic        timeout
);

    localparam int SEL_IDX = SLOT_SEL_BIT - ADDR_LSB;

    state_t           state, next_state;
    logic             lat_wr;
    logic [5:0]       lat_addr;
    logic [15:0]      lat_data;
    logic             tmr_load;
    logic [CNT_W-1:0] tmr_val;
    logic             tmr_zero;
    logic             active;
    logic             ext_start;   // last strobe cycle seen with iordy low
    logic             strobe_ok;   // strobe ends normally this cycle
    logic             strobe_to;   // strobe ends by timeout this cycle

    pbus_cycle_timer u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

`ifdef PBUS_SLOT_IORDY_EN
    logic ext;
    logic timeout_flag;

    assign ext_start = (state == STROBE) && tmr_zero && !ext && !iordy;
    assign strobe_ok = (state == STROBE) && iordy && (tmr_zero || ext);
    assign strobe_to = (state == STROBE) && ext && tmr_zero && !iordy;

    // Track strobe extension and the sticky timeout status.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ext          <= 1'b0;
            timeout_flag <= 1'b0;
        end else begin
            if (ext_start) begin
                ext <= 1'b1;
            end else if (strobe_ok || strobe_to) begin
                ext <= 1'b0;
            end
            if (strobe_ok || strobe_to) begin
                timeout_flag <= strobe_to;
            end
        end
    end

    assign timeout = timeout_flag;
`else
    logic iordy_unused;

    assign iordy_unused = iordy;
    assign ext_start    = 1'b0;
    assign strobe_ok    = (state == STROBE) && tmr_zero;
    assign strobe_to    = 1'b0;
    assign timeout      = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: non-blocking assignments in every clocked block, so all
        // flops sample pre-edge values regardless of block order.
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state and timer reload on each phase entry.
    always_comb begin
        // NOTE: defaults first, so every path assigns every signal and no
        // latch is inferred.
        next_state = state;
        tmr_load   = 1'b0;
        tmr_val    = '0;
        case (state)
            IDLE: begin
                if (en) begin
                    if (pbus_gnt) begin
                        next_state = SETUP;
                        tmr_load   = 1'b1;
                        tmr_val    = phase_load(SETUP_CYC);
                    end else begin
                        next_state = REQ;
                    end
                end
            end
            REQ: begin
                if (pbus_gnt) begin
                    next_state = SETUP;
                    tmr_load   = 1'b1;
                    tmr_val    = phase_load(SETUP_CYC);
                end
            end
            SETUP: begin
                if (tmr_zero) begin
                    next_state = STROBE;
                    tmr_load   = 1'b1;
                    tmr_val    = phase_load(STROBE_CYC);
                end
            end
            STROBE: begin
                if (ext_start) begin
                    tmr_load = 1'b1;
                    tmr_val  = phase_load(TIMEOUT_CYC);
                end else if (strobe_ok || strobe_to) begin
                    next_state = HOLD;
                    tmr_load   = 1'b1;
                    tmr_val    = phase_load(HOLD_CYC);
                end
            end
            HOLD: begin
                if (tmr_zero) begin
                    next_state = DONE;
                end
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Capture the CPU request when an access starts in IDLE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lat_wr   <= 1'b0;
            lat_addr <= '0;
            lat_data <= '0;
        end else if (state == IDLE && en) begin
            lat_wr   <= wr;
            lat_addr <= addr;
            lat_data <= data_in;
        end
    end

    // Read data: captured at the end of the strobe, all-ones on timeout.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_out <= '0;
        end else if (!lat_wr) begin
            if (strobe_ok) begin
                data_out <= pbus_d_in;
            end else if (strobe_to) begin
                data_out <= 16'hFFFF;
            end
        end
    end

    // Bus outputs decoded from state, so reset drops them without a clock.
    always_comb begin
        active       = (state == SETUP) || (state == STROBE) || (state == HOLD);
        pbus_req     = (state == IDLE && en) || (state == REQ) || active;
        pbus_a       = lat_addr[PA_W-1:0];
        pbus_d_out   = lat_data;
        pbus_d_oe    = active && lat_wr;
        slot1_cs_n   = !(active && !lat_addr[SEL_IDX]);
        slot2_cs_n   = !(active && lat_addr[SEL_IDX]);
        pbus_read_n  = !(state == STROBE && !lat_wr);
        pbus_write_n = !(state == STROBE && lat_wr);
        wt           = en && (state != DONE);
    end

endmodule

// File: tb/tb_pbus_slot.sv
// Bench for pbus_slot: hand-computed vector table, corner-case sequences and
// randomized accesses against a timing/data model built from the cycle rules.
module tb_pbus_slot;

    localparam int S  = 2;
    localparam int T  = 6;
    localparam int H  = 2;
    localparam int TO = 255;
`ifdef PBUS_SLOT_IORDY_EN
    localparam bit IORDY = 1'b1;
`else
    localparam bit IORDY = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic        wr;
    logic [5:0]  addr;
    logic [15:0] data_in;
    logic [15:0] data_out;
    logic        wt;
    logic        pbus_req;
    logic        pbus_gnt;
    logic [4:0]  pbus_a;
    logic [15:0] pbus_d_in;
    logic [15:0] pbus_d_out;
    logic        pbus_d_oe;
    logic        pbus_read_n;
    logic        pbus_write_n;
    logic        slot1_cs_n;
    logic        slot2_cs_n;
    logic        iordy;
    logic        timeout;

    pbus_slot #(
        .SETUP_CYC   (S),
        .STROBE_CYC  (T),
        .HOLD_CYC    (H),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .en           (en),
        .wr           (wr),
        .addr         (addr),
        .data_in      (data_in),
        .data_out     (data_out),
        .wt           (wt),
        .pbus_req     (pbus_req),
        .pbus_gnt     (pbus_gnt),
        .pbus_a       (pbus_a),
        .pbus_d_in    (pbus_d_in),
        .pbus_d_out   (pbus_d_out),
        .pbus_d_oe    (pbus_d_oe),
        .pbus_read_n  (pbus_read_n),
        .pbus_write_n (pbus_write_n),
        .slot1_cs_n   (slot1_cs_n),
        .slot2_cs_n   (slot2_cs_n),
        .iordy        (iordy),
        .timeout      (timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [5:0]  addr;
        logic [15:0] din;
        logic [15:0] pdin;
        int          gd;       // cycle in which grant first appears
        int          e_cs;     // first cycle with cs low
        int          e_st;     // first strobe cycle
        int          e_len;    // strobe length
        int          e_done;   // cycle with wt low
        logic [15:0] e_data;   // data_out after the access
    } vec_t;

    int          n_vec = 0;
    int          n_bad = 0;
    logic [15:0] last_rd = '0;
    vec_t        tbl[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference timing: grant in cycle gd, then fixed phase lengths, with
    // the strobe stretched by the iordy-low cycles up to the timeout.
    function automatic void model(input int gd, input int ilow,
                                  output int e_cs, output int e_st,
                                  output int e_len, output int e_done);
        int extra;
        extra  = IORDY ? ((ilow > TO) ? TO : ilow) : 0;
        e_cs   = gd + 1;
        e_st   = e_cs + S;
        e_len  = T + extra;
        e_done = e_st + e_len + H;
    endfunction

    // One access; cycle 0 is the cycle in which en is first sampled.
    task automatic run_access(input logic w, input logic [5:0] a,
                              input logic [15:0] din, input logic [15:0] pdin,
                              input int gd, input int ilow,
                              input int e_cs, input int e_st, input int e_len,
                              input int e_done, input logic [15:0] e_data,
                              input logic e_to, input string tag);
        int   cs_first = -1, cs_cnt = 0, st_first = -1, st_cnt = 0;
        int   done_c = -1, bad = 0;
        logic sel_n, oth_n, act_n, ina_n;
        @(negedge clk);
        en = 1'b1; wr = w; addr = a; data_in = din;
        pbus_gnt = (gd == 0); iordy = 1'b1; pbus_d_in = ~pdin;
        #1;
        check({tag, " req_immediate"}, pbus_req, 1);
        for (int c = 1; c < 700 && done_c < 0; c++) begin
            @(posedge clk);
            @(negedge clk);
            sel_n = a[5] ? slot2_cs_n : slot1_cs_n;
            oth_n = a[5] ? slot1_cs_n : slot2_cs_n;
            act_n = w ? pbus_write_n : pbus_read_n;
            ina_n = w ? pbus_read_n : pbus_write_n;
            if (!sel_n) begin
                cs_cnt++;
                if (cs_first < 0) cs_first = c;
                if (pbus_a != a[4:0]) bad++;
                if (pbus_d_oe != w) bad++;
                if (w && pbus_d_out != din) bad++;
                if (!pbus_req) bad++;
            end else if (pbus_d_oe) begin
                bad++;
            end
            if (!oth_n || !ina_n) bad++;
            if (!act_n) begin
                st_cnt++;
                if (st_first < 0) st_first = c;
            end
            if (!wt) begin
                done_c = c;
                if (pbus_req) bad++;
            end else begin
                pbus_gnt  = (c < gd) ? 1'b0 : ((c == gd) ? 1'b1 : 1'($urandom));
                iordy     = !(c >= e_st + T - 1 && c < e_st + T - 1 + ilow);
                pbus_d_in = (c == e_st + e_len - 1) ? pdin : ~pdin;
            end
        end
        en = 1'b0; pbus_gnt = 1'b0; iordy = 1'b1;
        check({tag, " cs_start"}, cs_first, e_cs);
        check({tag, " cs_cycles"}, cs_cnt, e_done - e_cs);
        check({tag, " strobe_start"}, st_first, e_st);
        check({tag, " strobe_len"}, st_cnt, e_len);
        check({tag, " done_cycle"}, done_c, e_done);
        check({tag, " bus_errors"}, bad, 0);
        @(posedge clk);
        @(negedge clk);
        check({tag, " idle_bus"}, {pbus_req, slot1_cs_n, slot2_cs_n, pbus_d_oe}, 4'b0110);
        check({tag, " data_out"}, data_out, e_data);
        check({tag, " timeout"}, timeout, e_to);
    endtask

    initial begin
        int   c_cs, c_st, c_len, c_done, gap, hi_cnt, pulses, dones;
        logic rd, prev_rd, rw;
        logic [5:0]  ra;
        logic [15:0] rdin, rpdin;
        int   rgd, rilow;

        reset = 1'b1; en = 1'b0; wr = 1'b0; addr = '0; data_in = '0;
        pbus_gnt = 1'b0; pbus_d_in = '0; iordy = 1'b1;

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset strobes_cs", {pbus_read_n, pbus_write_n, slot1_cs_n, slot2_cs_n}, 4'hF);
        check("reset oe_req_wt", {pbus_d_oe, pbus_req, wt, timeout}, 4'h0);
        check("reset data", {data_out, pbus_d_out, 11'h0, pbus_a}, 0);
        reset = 1'b0;

        // Hand-computed vectors: wr, addr, din, pdin, gd, cs, st, len, done, data.
        tbl[0] = '{1'b0, 6'h05, 16'h0000, 16'hA5C3, 0, 1, 3, 6, 11, 16'hA5C3};
        tbl[1] = '{1'b1, 6'h21, 16'h1234, 16'h0000, 4, 5, 7, 6, 15, 16'hA5C3};
        tbl[2] = '{1'b0, 6'h3F, 16'h0000, 16'h5A5A, 1, 2, 4, 6, 12, 16'h5A5A};
        tbl[3] = '{1'b1, 6'h00, 16'hFFFF, 16'h0000, 2, 3, 5, 6, 13, 16'h5A5A};
        for (int i = 0; i < 4; i++) begin
            run_access(tbl[i].wr, tbl[i].addr, tbl[i].din, tbl[i].pdin, tbl[i].gd, 0,
                       tbl[i].e_cs, tbl[i].e_st, tbl[i].e_len, tbl[i].e_done,
                       tbl[i].e_data, 1'b0, $sformatf("vec%0d", i));
            last_rd = tbl[i].e_data;
        end

        // iordy held low for three cycles from the last nominal strobe cycle.
`ifdef PBUS_SLOT_IORDY_EN
        run_access(1'b0, 6'h07, 16'h0, 16'h3C3C, 0, 3, 1, 3, 9, 14, 16'h3C3C, 1'b0, "iordy3");
        run_access(1'b0, 6'h27, 16'h0, 16'h7777, 0, 300, 1, 3, 261, 266, 16'hFFFF, 1'b1, "iordy_stuck");
        run_access(1'b1, 6'h02, 16'h4321, 16'h0, 0, 0, 1, 3, 6, 11, 16'hFFFF, 1'b0, "timeout_clear");
        last_rd = 16'hFFFF;
`else
        run_access(1'b0, 6'h07, 16'h0, 16'h3C3C, 0, 3, 1, 3, 6, 11, 16'h3C3C, 1'b0, "iordy_ignored");
        last_rd = 16'h3C3C;
`endif

        // Reset in the middle of a write strobe.
        @(negedge clk);
        en = 1'b1; wr = 1'b1; addr = 6'h21; data_in = 16'hBEEF; pbus_gnt = 1'b1;
        repeat (5) begin
            @(posedge clk);
            @(negedge clk);
        end
        check("midrst strobe_before", {pbus_write_n, slot2_cs_n, pbus_d_oe}, 3'b001);
        #2 reset = 1'b1;
        #1;
        check("midrst async_release", {pbus_write_n, slot2_cs_n, slot1_cs_n, pbus_d_oe}, 4'b1110);
        en = 1'b0; pbus_gnt = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        check("midrst data_out", data_out, 0);
        last_rd = '0;
        run_access(1'b0, 6'h11, 16'h0, 16'h0F0F, 0, 0, 1, 3, 6, 11, 16'h0F0F, 1'b0, "after_rst");
        last_rd = 16'h0F0F;

        // Back-to-back reads with en held high.
        @(negedge clk);
        en = 1'b1; wr = 1'b0; addr = 6'h05; pbus_gnt = 1'b1; pbus_d_in = 16'h1111;
        prev_rd = 1'b1; hi_cnt = 0; gap = 0; pulses = 0; dones = 0;
        for (int c = 1; c < 60 && dones < 2; c++) begin
            @(posedge clk);
            @(negedge clk);
            rd = pbus_read_n;
            if (!rd && prev_rd) begin
                pulses++;
                if (pulses == 2) gap = hi_cnt;
            end
            hi_cnt = rd ? hi_cnt + 1 : 0;
            if (!wt) dones++;
            prev_rd = rd;
        end
        en = 1'b0; pbus_gnt = 1'b0;
        check("b2b dones", dones, 2);
        check("b2b pulses", pulses, 2);
        check("b2b gap_ok", (gap >= S + H + 1), 1);
        @(posedge clk);
        @(negedge clk);
        check("b2b data_out", data_out, 16'h1111);
        last_rd = 16'h1111;

        // Randomized accesses against the model.
        for (int i = 0; i < 24; i++) begin
            rw    = 1'($urandom);
            ra    = 6'($urandom);
            rdin  = 16'($urandom);
            rpdin = 16'($urandom);
            rgd   = $urandom_range(0, 5);
            rilow = $urandom_range(0, 4);
            model(rgd, rilow, c_cs, c_st, c_len, c_done);
            if (!rw) last_rd = rpdin;
            run_access(rw, ra, rdin, rpdin, rgd, rilow, c_cs, c_st, c_len, c_done,
                       last_rd, 1'b0, $sformatf("rnd%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
